// File: rtl/ethernet_tx_fcs_sequencer.sv
// Ethernet TX frame sequencer.
// Forwards a payload stream, pads short frames with zeros, appends the FCS
// read from an external byte-wide CRC-32 engine, then enforces the inter-frame gap.
module ethernet_tx_fcs_sequencer #(
    parameter int MIN_PAYLOAD = 60,
    parameter int IFG_CYCLES  = 12
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic [7:0]  s_data_i,
    input  logic        s_valid_i,
    input  logic        s_last_i,
    output logic        s_ready_o,
    output logic [7:0]  m_data_o,
    output logic        m_valid_o,
    output logic        m_last_o,
    input  logic        m_ready_i,
    output logic        crc_initialize_o,
    output logic        crc_compute_o,
    output logic [7:0]  crc_data_o,
    input  logic [31:0] crc32_i,
    output logic        busy_o,
    output logic        frame_done_o
);

    typedef enum logic [2:0] {
        IDLE,
        PAYLOAD,
        PAD,
        FCS,
        IFG
    } state_t;

    localparam logic [10:0] CNT_MAX  = 11'h7FF;
    localparam logic [11:0] MIN_P    = 12'(MIN_PAYLOAD);
    localparam logic [7:0]  IFG_LAST = 8'(IFG_CYCLES - 1);

    state_t      state_q, state_d;
    logic [10:0] cnt_q, cnt_d;
    logic [1:0]  idx_q, idx_d;
    logic [7:0]  ifg_q, ifg_d;
    logic [11:0] cnt_inc;
    logic [7:0]  fcs_byte;

    // Byte count after the current transfer, one bit wider so the compare never wraps.
    assign cnt_inc = {1'b0, cnt_q} + 12'd1;

    // The CRC engine always sees exactly the byte presented downstream.
    assign crc_data_o = m_data_o;
    assign busy_o     = (state_q != IDLE);

    // Select the FCS byte, low byte first; the engine holds the complemented-form residue.
    always_comb begin
        fcs_byte = 8'h00;
        unique case (idx_q)
            2'd0: fcs_byte = ~crc32_i[7:0];
            2'd1: fcs_byte = ~crc32_i[15:8];
            2'd2: fcs_byte = ~crc32_i[23:16];
            2'd3: fcs_byte = ~crc32_i[31:24];
            default: fcs_byte = 8'h00;
        endcase
    end

    // Next-state and output decode; every register only moves on a downstream handshake.
    always_comb begin
        state_d          = state_q;
        cnt_d            = cnt_q;
        idx_d            = idx_q;
        ifg_d            = ifg_q;
        s_ready_o        = 1'b0;
        m_data_o         = 8'h00;
        m_valid_o        = 1'b0;
        m_last_o         = 1'b0;
        crc_initialize_o = 1'b0;
        crc_compute_o    = 1'b0;
        frame_done_o     = 1'b0;

        unique case (state_q)
            IDLE: begin
                crc_initialize_o = 1'b1;
                if (s_valid_i) begin
                    state_d = PAYLOAD;
                    cnt_d   = 11'd0;
                    idx_d   = 2'd0;
                end
            end
            PAYLOAD: begin
                m_data_o  = s_data_i;
                m_valid_o = s_valid_i;
                s_ready_o = m_ready_i;
                if (s_valid_i && m_ready_i) begin
                    crc_compute_o = 1'b1;
                    if (cnt_q != CNT_MAX) begin
                        cnt_d = cnt_q + 11'd1;
                    end
                    if (s_last_i) begin
                        state_d = (cnt_inc < MIN_P) ? PAD : FCS;
                    end
                end
            end
            PAD: begin
                m_valid_o = 1'b1;
                if (m_ready_i) begin
                    crc_compute_o = 1'b1;
                    cnt_d         = cnt_q + 11'd1;
                    if (cnt_inc == MIN_P) begin
                        state_d = FCS;
                    end
                end
            end
            FCS: begin
                m_valid_o = 1'b1;
                m_data_o  = fcs_byte;
                m_last_o  = (idx_q == 2'd3);
                if (m_ready_i) begin
                    idx_d = idx_q + 2'd1;
                    if (idx_q == 2'd3) begin
                        frame_done_o = 1'b1;
                        state_d      = IFG;
                        ifg_d        = 8'd0;
                    end
                end
            end
            IFG: begin
                crc_initialize_o = 1'b1;
                if (ifg_q == IFG_LAST) begin
                    state_d = IDLE;
                end else begin
                    ifg_d = ifg_q + 8'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and counter registers; reset abandons any frame in flight.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
            cnt_q   <= 11'd0;
            idx_q   <= 2'd0;
            ifg_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            ifg_q   <= ifg_d;
        end
    end

endmodule

// File: tb/tb_ethernet_tx_fcs_sequencer.sv
// Testbench for ethernet_tx_fcs_sequencer with a byte-wide CRC-32 engine model
// attached and a frame-level reference model that builds the expected TX stream.
module tb_ethernet_tx_fcs_sequencer;

    localparam int MIN_PAYLOAD = 60;
    localparam int IFG_CYCLES  = 12;

    logic        clk_i;
    logic        rst_n_i;
    logic [7:0]  s_data_i;
    logic        s_valid_i;
    logic        s_last_i;
    logic        s_ready_o;
    logic [7:0]  m_data_o;
    logic        m_valid_o;
    logic        m_last_o;
    logic        m_ready_i;
    logic        crc_initialize_o;
    logic        crc_compute_o;
    logic [7:0]  crc_data_o;
    logic [31:0] crc32_i;
    logic        busy_o;
    logic        frame_done_o;

    typedef struct {
        logic [7:0] data;
        bit         last;
        bit         pay;
    } exp_t;

    exp_t        expQ[$];
    int          xfersLog[$];
    int          computesLog[$];
    int          vectors = 0;
    int          miscompares = 0;
    int          frameXfers = 0;
    int          frameComputes = 0;
    int          doneCount = 0;
    int          sinceDone = -1;
    int          lastGap = -1;
    int          stallRun = 0;
    int          lastStall = 0;
    int unsigned readyPct = 100;
    int unsigned gapPct = 0;
    int          stallLastLeft = 0;
    logic [31:0] engineReg;

    ethernet_tx_fcs_sequencer #(
        .MIN_PAYLOAD(MIN_PAYLOAD),
        .IFG_CYCLES (IFG_CYCLES)
    ) dut (
        .clk_i           (clk_i),
        .rst_n_i         (rst_n_i),
        .s_data_i        (s_data_i),
        .s_valid_i       (s_valid_i),
        .s_last_i        (s_last_i),
        .s_ready_o       (s_ready_o),
        .m_data_o        (m_data_o),
        .m_valid_o       (m_valid_o),
        .m_last_o        (m_last_o),
        .m_ready_i       (m_ready_i),
        .crc_initialize_o(crc_initialize_o),
        .crc_compute_o   (crc_compute_o),
        .crc_data_o      (crc_data_o),
        .crc32_i         (crc32_i),
        .busy_o          (busy_o),
        .frame_done_o    (frame_done_o)
    );

    // Reflected CRC-32 (poly 0x04C11DB7) over one byte, LSB first.
    function automatic logic [31:0] crcByte(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c ^ {24'h0, d};
        for (int b = 0; b < 8; b++) begin
            r = r[0] ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
        end
        return r;
    endfunction

    // Final Ethernet FCS value of a whole byte sequence.
    function automatic logic [31:0] crcOf(input logic [7:0] q[$]);
        logic [31:0] c;
        c = 32'hFFFF_FFFF;
        foreach (q[i]) c = crcByte(c, q[i]);
        return ~c;
    endfunction

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    // Byte-wide CRC engine: registered residue, reinitialised to all-ones.
    always @(posedge clk_i) begin
        if (crc_initialize_o) engineReg <= 32'hFFFF_FFFF;
        else if (crc_compute_o) engineReg <= crcByte(engineReg, crc_data_o);
    end
    assign crc32_i = engineReg;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic checkReset();
        checkOutput("rst_s_ready", 32'(s_ready_o), 32'd0);
        checkOutput("rst_m_valid", 32'(m_valid_o), 32'd0);
        checkOutput("rst_m_last", 32'(m_last_o), 32'd0);
        checkOutput("rst_m_data", 32'(m_data_o), 32'd0);
        checkOutput("rst_busy", 32'(busy_o), 32'd0);
        checkOutput("rst_done", 32'(frame_done_o), 32'd0);
        checkOutput("rst_compute", 32'(crc_compute_o), 32'd0);
        checkOutput("rst_crc_data", 32'(crc_data_o), 32'd0);
        checkOutput("rst_crc_init", 32'(crc_initialize_o), 32'd1);
    endtask

    task automatic checkFrame(input string name, input int idx, input int expX, input int expC);
        if (idx < xfersLog.size()) begin
            checkOutput({name, "_xfers"}, 32'(xfersLog[idx]), 32'(expX));
            checkOutput({name, "_computes"}, 32'(computesLog[idx]), 32'(expC));
        end else begin
            checkOutput({name, "_missing"}, 32'(xfersLog.size()), 32'(idx + 1));
        end
    endtask

    // Queue the expected TX bytes of one frame, then offer its payload on s.
    task automatic applyStimulus(input int len, input bit randomData);
        logic [7:0]  pay[$];
        logic [7:0]  frm[$];
        logic [31:0] fcs;
        exp_t        e;
        bit          acc;
        int          guard;
        for (int i = 0; i < len; i++) begin
            pay.push_back(randomData ? 8'($urandom_range(0, 255)) : 8'(i + 1));
        end
        frm = pay;
        while (frm.size() < MIN_PAYLOAD) frm.push_back(8'h00);
        fcs = crcOf(frm);
        foreach (frm[i]) begin
            e.data = frm[i];
            e.last = 1'b0;
            e.pay  = 1'b1;
            expQ.push_back(e);
        end
        for (int k = 0; k < 4; k++) begin
            e.data = fcs[8*k +: 8];
            e.last = (k == 3);
            e.pay  = 1'b0;
            expQ.push_back(e);
        end
        for (int i = 0; i < len; i++) begin
            if ($urandom_range(0, 99) < gapPct) begin
                s_valid_i = 1'b0;
                @(posedge clk_i);
                #1;
            end
            s_valid_i = 1'b1;
            s_data_i  = pay[i];
            s_last_i  = (i == len - 1);
            acc   = 1'b0;
            guard = 0;
            while (!acc) begin
                @(negedge clk_i);
                acc = s_ready_o;
                @(posedge clk_i);
                #1;
                guard++;
                if (!acc && guard > 5000) begin
                    checkOutput("s_accept_timeout", 32'd0, 32'd1);
                    s_valid_i = 1'b0;
                    s_last_i  = 1'b0;
                    return;
                end
            end
        end
        s_valid_i = 1'b0;
        s_last_i  = 1'b0;
    endtask

    task automatic waitDrain(input int budget);
        int n;
        n = 0;
        while (expQ.size() != 0 && n < budget) begin
            @(negedge clk_i);
            n++;
        end
        if (expQ.size() != 0) begin
            checkOutput("drain_timeout", 32'(expQ.size()), 32'd0);
            expQ.delete();
        end
        repeat (IFG_CYCLES + 3) @(negedge clk_i);
    endtask

    // Downstream ready: random at the requested rate, or forced low on the last FCS byte.
    initial begin
        m_ready_i = 1'b1;
        forever begin
            @(posedge clk_i);
            #1;
            if (stallLastLeft > 0 && m_valid_o && m_last_o) begin
                m_ready_i = 1'b0;
                stallLastLeft--;
            end else begin
                m_ready_i = ($urandom_range(0, 99) < readyPct);
            end
        end
    end

    // Compare DUT outputs against the expected byte stream every cycle.
    initial begin
        exp_t h;
        bit   doneNow;
        forever begin
            @(negedge clk_i);
            doneNow = 1'b0;
            if (rst_n_i) begin
                if (m_valid_o) begin
                    if (expQ.size() == 0) begin
                        checkOutput("spurious_valid", 32'd1, 32'd0);
                    end else begin
                        h = expQ[0];
                        checkOutput("m_data", 32'(m_data_o), 32'(h.data));
                        checkOutput("crc_data", 32'(crc_data_o), 32'(h.data));
                        checkOutput("m_last", 32'(m_last_o), 32'(h.last));
                        if (m_ready_i) begin
                            checkOutput("crc_compute", 32'(crc_compute_o), 32'(h.pay));
                            checkOutput("frame_done", 32'(frame_done_o), 32'(h.last));
                            frameXfers++;
                            if (crc_compute_o) frameComputes++;
                            void'(expQ.pop_front());
                            if (h.last) begin
                                doneNow = 1'b1;
                                doneCount++;
                                xfersLog.push_back(frameXfers);
                                computesLog.push_back(frameComputes);
                                frameXfers    = 0;
                                frameComputes = 0;
                                lastStall     = stallRun;
                                stallRun      = 0;
                            end
                        end else begin
                            checkOutput("stall_compute", 32'(crc_compute_o), 32'd0);
                            checkOutput("stall_done", 32'(frame_done_o), 32'd0);
                            if (h.last) stallRun++;
                        end
                    end
                end else begin
                    checkOutput("novalid_last", 32'(m_last_o), 32'd0);
                    checkOutput("novalid_done", 32'(frame_done_o), 32'd0);
                    checkOutput("novalid_compute", 32'(crc_compute_o), 32'd0);
                end
                if (doneNow) begin
                    sinceDone = 0;
                end else if (sinceDone >= 0) begin
                    if (s_ready_o) begin
                        lastGap   = sinceDone;
                        sinceDone = -1;
                    end else begin
                        sinceDone++;
                    end
                end
            end
        end
    end

    // Test sequence.
    initial begin
        logic [7:0] pin[$];
        int         base;
        int         d0;
        int         n;
        int         len;
        rst_n_i   = 1'b1;
        s_valid_i = 1'b0;
        s_data_i  = 8'h00;
        s_last_i  = 1'b0;
        #1 rst_n_i = 1'b0;
        #1 checkReset();

        for (int i = 0; i < 9; i++) pin.push_back(8'(8'h31 + i));
        checkOutput("model_pin_crc", crcOf(pin), 32'hCBF4_3926);

        repeat (3) @(posedge clk_i);
        #1 rst_n_i = 1'b1;

        readyPct = 100;
        gapPct   = 0;
        base = xfersLog.size();
        d0   = doneCount;
        applyStimulus(10, 1'b0);
        waitDrain(2000);
        checkFrame("pad10", base, 64, 60);
        checkOutput("pad10_done_count", 32'(doneCount - d0), 32'd1);

        base = xfersLog.size();
        applyStimulus(60, 1'b1);
        waitDrain(2000);
        checkFrame("exact60", base, 64, 60);

        base = xfersLog.size();
        applyStimulus(1500, 1'b1);
        lastGap = -1;
        applyStimulus(5, 1'b1);
        waitDrain(4000);
        checkFrame("long1500", base, 1504, 1500);
        checkFrame("b2b5", base + 1, 64, 60);
        checkOutput("ifg_gap", 32'(lastGap), 32'(IFG_CYCLES + 1));

        base = xfersLog.size();
        applyStimulus(2100, 1'b1);
        waitDrain(4000);
        checkFrame("sat2100", base, 2104, 2100);

        readyPct = 50;
        base = xfersLog.size();
        applyStimulus(20, 1'b0);
        waitDrain(4000);
        checkFrame("stall20", base, 64, 60);

        for (int k = 0; k < 6; k++) begin
            len      = int'($urandom_range(1, 120));
            readyPct = $urandom_range(30, 100);
            gapPct   = $urandom_range(0, 30);
            base = xfersLog.size();
            applyStimulus(len, 1'b1);
            waitDrain(4000);
            checkFrame("rand", base, ((len < MIN_PAYLOAD) ? MIN_PAYLOAD : len) + 4,
                       (len < MIN_PAYLOAD) ? MIN_PAYLOAD : len);
        end

        readyPct      = 100;
        gapPct        = 0;
        stallLastLeft = 3;
        d0 = doneCount;
        applyStimulus(15, 1'b1);
        waitDrain(2000);
        checkOutput("last_stall_cycles", 32'(lastStall), 32'd3);
        checkOutput("last_stall_done_count", 32'(doneCount - d0), 32'd1);

        d0 = doneCount;
        applyStimulus(10, 1'b0);
        n = 0;
        while (frameXfers != 15 && n < 200) begin
            @(negedge clk_i);
            #1;
            n++;
        end
        checkOutput("reset_wait_timeout", 32'(frameXfers), 32'd15);
        rst_n_i = 1'b0;
        #1 checkReset();
        expQ.delete();
        frameXfers    = 0;
        frameComputes = 0;
        sinceDone     = -1;
        stallRun      = 0;
        repeat (3) @(posedge clk_i);
        #1 rst_n_i = 1'b1;
        checkOutput("abort_no_done", 32'(doneCount - d0), 32'd0);
        base = xfersLog.size();
        applyStimulus(25, 1'b1);
        waitDrain(2000);
        checkFrame("after_reset", base, 64, 60);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Watchdog so the run always ends.
    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/ethernet_tx_fcs_sequencer.md
# ethernet_tx_fcs_sequencer

Transmit-side frame sequencer that drives the byte-wide `ethernet_crc32` engine. It passes a MAC payload stream through to the TX byte stream and pads short frames with 0x00 up to the minimum payload length. It then appends the 4-byte FCS taken from the CRC engine and enforces an inter-frame gap. It sits between the TX frame buffer and the TX MAC/PHY byte interface, with one `ethernet_crc32` instance attached to its `crc_*` ports.

## Interface
- `MIN_PAYLOAD`, default 60: minimum number of bytes before the FCS (destination address through padding).
- `IFG_CYCLES`, default 12: idle cycles enforced after the last FCS byte; range 1..255.
- `clk_i`, input, 1: the single clock.
- `rst_n_i`, input, 1: reset, asynchronous and active-low.
- `s_data_i`, input, 8: payload byte from the frame buffer.
- `s_valid_i`, input, 1: payload byte valid.
- `s_last_i`, input, 1: marks the final payload byte of the frame.
- `s_ready_o`, output, 1: sequencer accepts the payload byte.
- `m_data_o`, output, 8: TX byte.
- `m_valid_o`, output, 1: TX byte valid.
- `m_last_o`, output, 1: marks the final FCS byte.
- `m_ready_i`, input, 1: downstream accepts the TX byte.
- `crc_initialize_o`, output, 1: drives `initialize_i` of the CRC engine.
- `crc_compute_o`, output, 1: drives `compute_i` of the CRC engine.
- `crc_data_o`, output, 8: drives `data_i` of the CRC engine.
- `crc32_i`, input, 32: `crc32_o` of the CRC engine.
- `busy_o`, output, 1: high in every state except IDLE.
- `frame_done_o`, output, 1: one-cycle pulse on the handshake of the last FCS byte.

## Operation
- A transfer on m occurs when `m_valid_o & m_ready_i`. A transfer on s occurs when `s_valid_i & s_ready_o`.
- States: IDLE, PAYLOAD, PAD, FCS, IFG. The state, an 11-bit byte counter `cnt` and a 2-bit FCS index `idx` are registered.
- **IDLE**
  - `crc_initialize_o`=1 and `s_ready_o`=0.
  - When `s_valid_i`=1, go to PAYLOAD and clear `cnt` and `idx`.
- **PAYLOAD** (pass-through)
  - `m_data_o`=`s_data_i`, `m_valid_o`=`s_valid_i` and `s_ready_o`=`m_ready_i`.
  - On each transfer, `crc_compute_o`=1 and `cnt` increments, saturating at 2047.
  - On a transfer with `s_last_i`=1: if `cnt`+1 < `MIN_PAYLOAD`, go to PAD; otherwise go to FCS.
- **PAD**
  - `m_data_o`=0x00, `m_valid_o`=1 and `s_ready_o`=0.
  - On each transfer, `crc_compute_o`=1 and `cnt` increments.
  - On the transfer that makes `cnt`==`MIN_PAYLOAD`, go to FCS.
- **FCS**
  - `m_valid_o`=1 and `m_data_o`=~`crc32_i`[8*`idx`+7 : 8*`idx`].
  - `crc_compute_o`=0, so `crc32_i` stays stable for all 4 bytes.
  - `idx` increments on each transfer. `m_last_o`=1 when `idx`==3.
  - On the transfer with `idx`==3, pulse `frame_done_o` and go to IFG.
- **IFG**
  - All valid/ready outputs are 0 and `crc_initialize_o`=1.
  - The state is held for `IFG_CYCLES` cycles, then returns to IDLE.
- `crc_data_o`=`m_data_o` at all times. `crc_compute_o` is asserted only on an m transfer in PAYLOAD or PAD.
- `m_last_o` is 0 outside the FCS state.
- A stall (`m_ready_i`=0) holds all state. The data and valid outputs stay stable until the handshake.
- `s_last_i` outside PAYLOAD is ignored. In PAYLOAD, bytes past the 2047 saturation point are still forwarded and CRC'd.

## Timing
- Reset (asynchronous assert) forces IDLE with `cnt`=0 and `idx`=0.
- Output values during reset:
  - `s_ready_o`, `m_valid_o`, `m_last_o`, `m_data_o`, `busy_o`, `frame_done_o` and `crc_compute_o` are all 0.
  - `crc_data_o`=0x00 and `crc_initialize_o`=1.
- Reset mid-frame aborts the frame immediately. No FCS and no `frame_done_o` are produced.
- Start latency: one cycle from `s_valid_i` high in IDLE to `s_ready_o` high in PAYLOAD. The CRC is already all-ones by then.
- PAYLOAD is zero-latency combinational pass-through. PAD and FCS each emit one byte per cycle when `m_ready_i`=1.
- Minimum frame time with no stalls: 1 + max(N, `MIN_PAYLOAD`) + 4 + `IFG_CYCLES` cycles, where N is the payload length.
- FCS bytes are read from `crc32_i` combinationally. The engine register holds its final value one cycle after the last PAYLOAD/PAD compute, which is before the first FCS cycle.

## Test plan
- **Padding:** 10-byte payload 0x01..0x0A, `m_ready_i`=1.
  - Output is 10 payload bytes, then 50 bytes of 0x00, then 4 FCS bytes: 64 m transfers in total.
  - `m_last_o` is high only on transfer 64, and `frame_done_o` pulses in the same cycle.
  - FCS equals ~CRC from a golden engine model over the 60 bytes.
- **Exact minimum:** 60-byte payload.
  - No PAD bytes; FCS follows immediately; 64 transfers.
- **Long frame:** 1500-byte payload.
  - 1504 transfers; `cnt` reaches 1500 with no saturation.
  - Back-to-back second frame: `s_ready_o` stays 0 for exactly 12 IFG cycles plus 1 IDLE cycle.
- **Stalls:** 20-byte frame with random `m_ready_i` (50%).
  - Byte sequence and FCS are identical to the unstalled run.
  - `crc_compute_o` count equals 60.
- **Reset mid-frame:** `rst_n_i` low during PAD byte 5.
  - All outputs go to their reset values asynchronously.
  - The next frame's FCS matches the golden model, proving the CRC was re-initialised.
- **Stall on last FCS byte:** `m_ready_i`=0 for 3 cycles at `idx`==3.
  - `m_last_o` and `m_data_o` are held steady during the stall.
  - `frame_done_o` pulses exactly once, on the handshake.
